// File: rtl/union_reg_arbiter.sv
// Two-requester round-robin access to one packed-union register (full word or either half).
// Response is registered one cycle after accept; withdrawn requests and reserved modes set sticky ERROR.
module union_reg_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_we,
   input  logic [3:0]         req_mode,
   input  logic [2*WIDTH-1:0] req_wdata,
   output logic [1:0]         rsp_valid,
   output logic [WIDTH-1:0]   rsp_rdata,
   output logic               ERROR
);

   localparam int HW = WIDTH / 2;

   typedef struct packed {
      logic [HW-1:0] hi;
      logic [HW-1:0] lo;
   } half_t;

   typedef union packed {
      logic [WIDTH-1:0] raw;
      half_t            half;
   } store_t;

   store_t           store;
   store_t           store_nxt;
   logic             last_grant;
   logic [1:0]       pend;
   logic [WIDTH-1:0] rdata_nxt;
   logic             err_nxt;
   logic             idx;
   logic             we;
   logic [1:0]       mode;
   logic [WIDTH-1:0] wdata;

   // Contention goes to the requester that was not granted last; ready is held low in reset.
   always_comb begin
      req_ready = 2'b00;
      if (!rst) begin
         if (req_valid == 2'b11)
            req_ready = last_grant ? 2'b01 : 2'b10;
         else
            req_ready = req_valid;
      end
   end

   assign idx   = req_ready[1];
   assign we    = req_we[idx];
   assign mode  = idx ? req_mode[3:2] : req_mode[1:0];
   assign wdata = idx ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];

   always_comb begin
      store_nxt = store;
      rdata_nxt = rsp_rdata;
      err_nxt   = ERROR;
      for (int i = 0; i < 2; i++) begin
         if (pend[i] && !req_valid[i])
            err_nxt = 1'b1;
      end
      if (|req_ready) begin
         case (mode)
            2'b00: begin
               if (we)
                  store_nxt.raw = wdata;
               rdata_nxt = store_nxt.raw;
            end
            2'b01: begin
               if (we)
                  store_nxt.half.lo = wdata[HW-1:0];
               rdata_nxt = {{(WIDTH-HW){1'b0}}, store_nxt.half.lo};
            end
            2'b10: begin
               if (we)
                  store_nxt.half.hi = wdata[HW-1:0];
               rdata_nxt = {{(WIDTH-HW){1'b0}}, store_nxt.half.hi};
            end
            default: begin
               rdata_nxt = '0;
               err_nxt   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         store      <= '0;
         last_grant <= 1'b1;
         pend       <= 2'b00;
         rsp_valid  <= 2'b00;
         rsp_rdata  <= '0;
         ERROR      <= 1'b0;
      end else begin
         store     <= store_nxt;
         pend      <= req_valid & ~req_ready;
         rsp_valid <= req_ready;
         rsp_rdata <= rdata_nxt;
         ERROR     <= err_nxt;
         if (|req_ready)
            last_grant <= idx;
      end
   end

endmodule

// File: tb/tb_union_reg_arbiter.sv
// Bench for union_reg_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_union_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_we = '0;
   logic [3:0]  req_mode = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        ERROR;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [7:0] m_store;
   int         m_last;
   logic       m_err;
   logic [1:0] m_pend;
   logic [1:0] exp_rv;
   logic [7:0] exp_rd;

   union_reg_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_mode(req_mode), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ERROR(ERROR)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] model_ready(input logic [1:0] v);
      if (v == 2'b11)
         return (m_last == 0) ? 2'b10 : 2'b01;
      return v;
   endfunction

   task automatic model_reset();
      m_store = 8'h00; m_last = 1; m_err = 1'b0; m_pend = 2'b00;
      exp_rv = 2'b00; exp_rd = 8'h00;
   endtask

   // Apply the rules for one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [1:0] g;
      logic [1:0] md;
      logic [7:0] wd;
      int k;
      g = model_ready(req_valid);
      for (int i = 0; i < 2; i++)
         if (m_pend[i] && !req_valid[i]) m_err = 1'b1;
      m_pend = req_valid & ~g;
      exp_rv = g;
      if (g != 2'b00) begin
         k  = g[1] ? 1 : 0;
         md = req_mode[2*k +: 2];
         wd = req_wdata[8*k +: 8];
         case (md)
            2'd0: begin
               if (req_we[k]) m_store = wd;
               exp_rd = m_store;
            end
            2'd1: begin
               if (req_we[k]) m_store = (m_store & 8'hF0) | (wd & 8'h0F);
               exp_rd = m_store & 8'h0F;
            end
            2'd2: begin
               if (req_we[k]) m_store = (m_store & 8'h0F) | ((wd & 8'h0F) << 4);
               exp_rd = m_store >> 4;
            end
            default: begin
               exp_rd = 8'h00;
               m_err  = 1'b1;
            end
         endcase
         m_last = k;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0; req_we = '0; req_mode = '0; req_wdata = '0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
   endtask

   task automatic single_req(input int i, input logic we, input logic [1:0] md, input logic [7:0] wd);
      idle();
      req_valid[i]       = 1'b1;
      req_we[i]          = we;
      req_mode[2*i +: 2] = md;
      req_wdata[8*i +: 8] = wd;
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      req_valid = 2'b11;
      #2;
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want %b", req_ready, 2'b00); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got %b want %b", rsp_valid, 2'b00); end
      n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want %h", rsp_rdata, 8'h00); end
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want %b", ERROR, 1'b0); end
      do_reset();
   endtask

   task automatic test_full_and_halves();
      do_reset();
      single_req(0, 1'b1, 2'b00, 8'h8C);
      n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL wr_full_rv got %b want %b", rsp_valid, 2'b01); end
      n_cmp++; if (rsp_rdata !== 8'h8C) begin n_bad++; $display("FAIL wr_full_rd got %h want %h", rsp_rdata, 8'h8C); end
      single_req(1, 1'b0, 2'b00, 8'h00);
      n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL rd_full_rv got %b want %b", rsp_valid, 2'b10); end
      n_cmp++; if (rsp_rdata !== 8'h8C) begin n_bad++; $display("FAIL rd_full_rd got %h want %h", rsp_rdata, 8'h8C); end
      single_req(1, 1'b0, 2'b01, 8'hFF);
      n_cmp++; if (rsp_rdata !== 8'h0C) begin n_bad++; $display("FAIL rd_lo got %h want %h", rsp_rdata, 8'h0C); end
      single_req(1, 1'b0, 2'b10, 8'hFF);
      n_cmp++; if (rsp_rdata !== 8'h08) begin n_bad++; $display("FAIL rd_hi got %h want %h", rsp_rdata, 8'h08); end
   endtask

   task automatic test_half_write();
      single_req(0, 1'b1, 2'b10, 8'h05);
      n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL wr_hi_rv got %b want %b", rsp_valid, 2'b01); end
      n_cmp++; if (rsp_rdata !== 8'h05) begin n_bad++; $display("FAIL wr_hi_rd got %h want %h", rsp_rdata, 8'h05); end
      single_req(0, 1'b0, 2'b00, 8'h00);
      n_cmp++; if (rsp_rdata !== 8'h5C) begin n_bad++; $display("FAIL rd_after_hi got %h want %h", rsp_rdata, 8'h5C); end
      tick();
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL hold_rv got %b want %b", rsp_valid, 2'b00); end
      n_cmp++; if (rsp_rdata !== 8'h5C) begin n_bad++; $display("FAIL hold_rd got %h want %h", rsp_rdata, 8'h5C); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] want;
      logic [1:0] prev;
      do_reset();
      req_valid = 2'b11;
      #1;
      prev = 2'b00;
      for (int c = 0; c < 4; c++) begin
         want = (c % 2 == 0) ? 2'b01 : 2'b10;
         n_cmp++; if (req_ready !== want) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want %b", c, req_ready, want); end
         n_cmp++; if (rsp_valid !== prev) begin n_bad++; $display("FAIL b2b_rv[%0d] got %b want %b", c, rsp_valid, prev); end
         prev = want;
         tick();
      end
      idle();
      n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL b2b_last_rv got %b want %b", rsp_valid, 2'b10); end
      tick();
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL b2b_pulse got %b want %b", rsp_valid, 2'b00); end
   endtask

   task automatic test_bad_mode();
      single_req(0, 1'b1, 2'b00, 8'h9A);
      single_req(1, 1'b1, 2'b11, 8'h77);
      n_cmp++; if (rsp_valid !== 2'b10) begin n_bad++; $display("FAIL mode11_rv got %b want %b", rsp_valid, 2'b10); end
      n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL mode11_rd got %h want %h", rsp_rdata, 8'h00); end
      n_cmp++; if (ERROR !== 1'b1) begin n_bad++; $display("FAIL mode11_err got %b want %b", ERROR, 1'b1); end
      single_req(0, 1'b0, 2'b00, 8'h00);
      n_cmp++; if (rsp_rdata !== 8'h9A) begin n_bad++; $display("FAIL mode11_store got %h want %h", rsp_rdata, 8'h9A); end
      single_req(0, 1'b1, 2'b00, 8'h3C);
      tick();
      n_cmp++; if (ERROR !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want %b", ERROR, 1'b1); end
   endtask

   task automatic test_withdraw();
      do_reset();
      single_req(1, 1'b1, 2'b00, 8'hA5);
      req_valid = 2'b11; req_we = 2'b10; req_mode = 4'b0000; req_wdata = 16'hFF00;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL wd_ready got %b want %b", req_ready, 2'b01); end
      tick();
      idle();
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL wd_err_early got %b want %b", ERROR, 1'b0); end
      n_cmp++; if (rsp_rdata !== 8'hA5) begin n_bad++; $display("FAIL wd_rd got %h want %h", rsp_rdata, 8'hA5); end
      tick();
      n_cmp++; if (ERROR !== 1'b1) begin n_bad++; $display("FAIL wd_err got %b want %b", ERROR, 1'b1); end
      single_req(0, 1'b0, 2'b00, 8'h00);
      n_cmp++; if (rsp_rdata !== 8'hA5) begin n_bad++; $display("FAIL wd_store got %h want %h", rsp_rdata, 8'hA5); end
   endtask

   task automatic test_async_reset();
      do_reset();
      single_req(1, 1'b1, 2'b11, 8'h00);
      idle();
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[7:0] = 8'h77;
      model_edge();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL arst_rv got %b want %b", rsp_valid, 2'b00); end
      n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL arst_rd got %h want %h", rsp_rdata, 8'h00); end
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL arst_err got %b want %b", ERROR, 1'b0); end
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL arst_ready got %b want %b", req_ready, 2'b00); end
      idle();
      #2;
      rst = 1'b0;
      tick();
      n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL arst_release_rv got %b want %b", rsp_valid, 2'b00); end
      req_valid = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL arst_first_grant got %b want %b", req_ready, 2'b01); end
      tick();
      idle();
      n_cmp++; if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL arst_store got %h want %h", rsp_rdata, 8'h00); end
   endtask

   task automatic test_random();
      logic [1:0] v;
      logic [1:0] md;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         for (int i = 0; i < 2; i++) begin
            if (m_pend[i]) v[i] = ($urandom_range(0, 9) != 0);
            else           v[i] = $urandom_range(0, 1) == 1;
            md = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            req_mode[2*i +: 2] = md;
            req_we[i]          = $urandom_range(0, 1) == 1;
            req_wdata[8*i +: 8] = 8'($urandom);
         end
         req_valid = v;
         #1;
         n_cmp++; if (req_ready !== model_ready(req_valid)) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b want %b", n, req_ready, model_ready(req_valid)); end
         tick();
         n_cmp++; if (rsp_valid !== exp_rv) begin n_bad++; $display("FAIL rnd_rv[%0d] got %b want %b", n, rsp_valid, exp_rv); end
         n_cmp++; if (rsp_rdata !== exp_rd) begin n_bad++; $display("FAIL rnd_rd[%0d] got %h want %h", n, rsp_rdata, exp_rd); end
         n_cmp++; if (ERROR !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d] got %b want %b", n, ERROR, m_err); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_full_and_halves();
      test_half_write();
      test_back_to_back();
      test_bad_mode();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
